// File: rtl/polyphase_coeff_loader.sv
// polyphase_coeff_loader: coefficient bank and reload sequencer in front of the polyphase filter
module polyphase_coeff_loader #(
  parameter int NUMBER_TAPS       = 32,
  parameter int COEFFICIENT_WIDTH = 16,
  parameter int DATA_IN_WIDTH     = 16,
  parameter int RESET_CYCLES      = 4
) (
  input  logic                             aclk,
  input  logic                             aresetn,
  input  logic                             cfg_wr_en,
  input  logic [$clog2(NUMBER_TAPS)-1:0]   cfg_wr_addr,
  input  logic [COEFFICIENT_WIDTH-1:0]     cfg_wr_data,
  output logic                             cfg_wr_err,
  input  logic                             reload_req,
  output logic                             busy,
  output logic                             load_done,
  output logic                             loaded,
  input  logic [DATA_IN_WIDTH-1:0]         s_data_tdata,
  input  logic                             s_data_tvalid,
  input  logic                             s_data_tlast,
  output logic                             s_data_tready,
  output logic [DATA_IN_WIDTH-1:0]         m_data_tdata,
  output logic                             m_data_tvalid,
  output logic                             m_data_tlast,
  input  logic                             m_data_tready,
  output logic                             filt_aresetn,
  output logic [COEFFICIENT_WIDTH-1:0]     coef_tdata,
  output logic                             coef_tvalid,
  output logic                             coef_tlast,
  input  logic                             coef_tready
);
  localparam int AW = $clog2(NUMBER_TAPS);
  localparam int CW = $clog2(RESET_CYCLES + 1);
  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] RUN   = 3'd1;
  localparam logic [2:0] DRAIN = 3'd2;
  localparam logic [2:0] HOLD  = 3'd3;
  localparam logic [2:0] LOAD  = 3'd4;

  logic [COEFFICIENT_WIDTH-1:0] bank [NUMBER_TAPS];
  logic [2:0]    state, state_nxt;
  logic [AW-1:0] addr, addr_inc;
  logic [CW-1:0] cnt;
  logic          in_frame, pass, s_hs, c_hs;

  always_comb begin
    busy      = (state == DRAIN) || (state == HOLD) || (state == LOAD);
    pass      = (state == RUN) || ((state == DRAIN) && in_frame);
    s_hs      = s_data_tvalid && s_data_tready;
    c_hs      = coef_tvalid && coef_tready;
    addr_inc  = addr + 1'b1;
    state_nxt = ((state == IDLE) || (state == RUN)) && reload_req ? DRAIN :
                (state == DRAIN) && !in_frame                     ? HOLD  :
                (state == HOLD) && (cnt == '0)                    ? LOAD  :
                (state == LOAD) && c_hs && coef_tlast             ? RUN   : state;
  end

  assign m_data_tdata  = s_data_tdata;
  assign m_data_tlast  = s_data_tlast;
  assign m_data_tvalid = s_data_tvalid && pass;
  assign s_data_tready = m_data_tready && pass;

  // Bank survives reset; writes are refused while a load sequence owns it
  always_ff @(posedge aclk)
    if (cfg_wr_en && !busy) bank[cfg_wr_addr] <= cfg_wr_data;

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state        <= IDLE;
      in_frame     <= 1'b0;
      addr         <= '0;
      cnt          <= '0;
      coef_tvalid  <= 1'b0;
      coef_tlast   <= 1'b0;
      coef_tdata   <= '0;
      load_done    <= 1'b0;
      loaded       <= 1'b0;
      cfg_wr_err   <= 1'b0;
      filt_aresetn <= 1'b0;
    end else begin
      state        <= state_nxt;
      filt_aresetn <= state_nxt != HOLD;
      cfg_wr_err   <= cfg_wr_en && busy;
      load_done    <= (state == LOAD) && c_hs && coef_tlast;
      if (s_hs) in_frame <= !s_data_tlast;
      if ((state == DRAIN) && !in_frame) cnt <= CW'(RESET_CYCLES - 1);
      else if ((state == HOLD) && (cnt != '0)) cnt <= cnt - 1'b1;
      // First word is presented on the HOLD->LOAD edge, so tvalid is up on LOAD entry
      if ((state == HOLD) && (cnt == '0)) begin
        addr        <= '0;
        coef_tvalid <= 1'b1;
        coef_tdata  <= bank[0];
        coef_tlast  <= 1'b0;
      end else if (c_hs) begin
        addr <= addr_inc;
        if (coef_tlast) begin
          coef_tvalid <= 1'b0;
          coef_tlast  <= 1'b0;
          loaded      <= 1'b1;
        end else begin
          coef_tdata <= bank[addr_inc];
          coef_tlast <= &addr_inc;
        end
      end
    end
  end
endmodule
